// File: rtl/nn_layer_sequencer.sv
// Layer chain controller: launches masked layer engines in order, arbitrates the
// shared feature RAM / weight ROM port, and reports watchdog, abort and run status.
module nn_layer_sequencer #(
   parameter int NUM_STAGES = 8,
   parameter int RAM_AW     = 16,
   parameter int RAM_DW     = 8,
   parameter int ROMW_AW    = 16,
   parameter int ROWO_AW    = 9,
   parameter int TO_W       = 24
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic                          start_flag,
   input  logic                          abort,
   input  logic [NUM_STAGES-1:0]         stage_mask,
   output logic                          end_flag,
   output logic                          busy,
   output logic                          err_timeout,
   output logic                          err_spurious,
   output logic [3:0]                    cur_stage,
   output logic [31:0]                   run_cycles,
   output logic [NUM_STAGES-1:0]         stg_start,
   input  logic [NUM_STAGES-1:0]         stg_end,
   input  logic [NUM_STAGES*RAM_AW-1:0]  stg_ram_addr_w,
   input  logic [NUM_STAGES*RAM_DW-1:0]  stg_ram_data_w,
   input  logic [NUM_STAGES-1:0]         stg_ram_en,
   input  logic [NUM_STAGES-1:0]         stg_ram_wea,
   input  logic [NUM_STAGES*RAM_AW-1:0]  stg_ram_addr_r,
   input  logic [NUM_STAGES-1:0]         stg_ram_en_r,
   input  logic [NUM_STAGES*ROMW_AW-1:0] stg_rom_addr_rw,
   input  logic [NUM_STAGES-1:0]         stg_rom_en_rw,
   input  logic [NUM_STAGES*ROWO_AW-1:0] stg_rom_addr_row,
   input  logic [NUM_STAGES-1:0]         stg_rom_en_row,
   output logic [RAM_AW-1:0]             ram_addr_w,
   output logic [RAM_DW-1:0]             ram_data_w,
   output logic                          ram_en,
   output logic                          ram_wea,
   output logic [RAM_AW-1:0]             ram_addr_r,
   output logic                          ram_en_r,
   output logic [ROMW_AW-1:0]            rom_addr_rw,
   output logic                          rom_en_rw,
   output logic [ROWO_AW-1:0]            rom_addr_row,
   output logic                          rom_en_row
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_FINISH
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic [NUM_STAGES-1:0]   mask_q, mask_d;
   logic [TO_W-1:0]         wdog_q, wdog_d;
   logic [NUM_STAGES-1:0]   stgStart_q, stgStart_d;
   logic                    endFlag_q, endFlag_d;
   logic                    busy_q, busy_d;
   logic                    errTimeout_q, errTimeout_d;
   logic                    errSpurious_q, errSpurious_d;
   logic [31:0]             runCycles_q, runCycles_d;

   logic [3:0]              lowestIdx, nextIdx;
   logic                    lowestFound, nextFound;
   logic [NUM_STAGES-1:0]   selOneHot;
   logic                    endHit, spurious, active, startAccept;

   // Scanning from the top down leaves the lowest qualifying index as the final assignment.
   always_comb begin
      lowestIdx   = '0;
      lowestFound = 1'b0;
      nextIdx     = '0;
      nextFound   = 1'b0;
      selOneHot   = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (stage_mask[k]) begin
            lowestIdx   = 4'(k);
            lowestFound = 1'b1;
         end
         if (mask_q[k] && (4'(k) > idx_q)) begin
            nextIdx   = 4'(k);
            nextFound = 1'b1;
         end
         selOneHot[k] = (idx_q == 4'(k));
      end
   end

   assign active      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
   assign endHit      = (state_q == ST_WAIT) && |(stg_end & selOneHot);
   assign spurious    = (state_q == ST_WAIT) ? |(stg_end & ~selOneHot) : |stg_end;
   assign startAccept = (state_q == ST_IDLE) && start_flag && !busy_q;

   // Busy stays up through the end_flag cycle so the run counter includes it.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      mask_d        = mask_q;
      wdog_d        = wdog_q;
      stgStart_d    = '0;
      endFlag_d     = 1'b0;
      busy_d        = endFlag_q ? 1'b0 : busy_q;
      errTimeout_d  = errTimeout_q;
      errSpurious_d = errSpurious_q | spurious;
      runCycles_d   = (busy_q && (runCycles_q != 32'hFFFF_FFFF)) ? runCycles_q + 32'd1
                                                                 : runCycles_q;
      unique case (state_q)
         ST_IDLE: begin
            if (startAccept) begin
               mask_d        = stage_mask;
               errTimeout_d  = 1'b0;
               errSpurious_d = spurious;
               runCycles_d   = '0;
               busy_d        = 1'b1;
               wdog_d        = '0;
               if (lowestFound) begin
                  idx_d   = lowestIdx;
                  state_d = ST_LAUNCH;
               end else begin
                  idx_d   = '0;
                  state_d = ST_FINISH;
               end
            end
         end
         ST_LAUNCH: begin
            if (abort) begin
               state_d = ST_FINISH;
            end else begin
               stgStart_d = selOneHot;
               wdog_d     = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Abort outranks a completing stage, which outranks the watchdog.
            if (abort) begin
               state_d = ST_FINISH;
            end else if (endHit) begin
               if (nextFound) begin
                  idx_d   = nextIdx;
                  state_d = ST_LAUNCH;
               end else begin
                  state_d = ST_FINISH;
               end
            end else if (wdog_q == '1) begin
               errTimeout_d = 1'b1;
               state_d      = ST_FINISH;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_FINISH: begin
            endFlag_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         mask_q        <= '0;
         wdog_q        <= '0;
         stgStart_q    <= '0;
         endFlag_q     <= 1'b0;
         busy_q        <= 1'b0;
         errTimeout_q  <= 1'b0;
         errSpurious_q <= 1'b0;
         runCycles_q   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         wdog_q        <= wdog_d;
         stgStart_q    <= stgStart_d;
         endFlag_q     <= endFlag_d;
         busy_q        <= busy_d;
         errTimeout_q  <= errTimeout_d;
         errSpurious_q <= errSpurious_d;
         runCycles_q   <= runCycles_d;
      end
   end

   assign end_flag     = endFlag_q;
   assign busy         = busy_q;
   assign err_timeout  = errTimeout_q;
   assign err_spurious = errSpurious_q;
   assign cur_stage    = active ? idx_q : 4'd0;
   assign run_cycles   = runCycles_q;
   assign stg_start    = stgStart_q;

   // Shared memory port follows the registered stage index; parked at zero outside a stage.
   always_comb begin
      ram_addr_w   = '0;
      ram_data_w   = '0;
      ram_en       = 1'b0;
      ram_wea      = 1'b0;
      ram_addr_r   = '0;
      ram_en_r     = 1'b0;
      rom_addr_rw  = '0;
      rom_en_rw    = 1'b0;
      rom_addr_row = '0;
      rom_en_row   = 1'b0;
      if (active) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == 4'(k)) begin
               ram_addr_w   = stg_ram_addr_w[k*RAM_AW +: RAM_AW];
               ram_data_w   = stg_ram_data_w[k*RAM_DW +: RAM_DW];
               ram_en       = stg_ram_en[k];
               ram_wea      = stg_ram_wea[k];
               ram_addr_r   = stg_ram_addr_r[k*RAM_AW +: RAM_AW];
               ram_en_r     = stg_ram_en_r[k];
               rom_addr_rw  = stg_rom_addr_rw[k*ROMW_AW +: ROMW_AW];
               rom_en_rw    = stg_rom_en_rw[k];
               rom_addr_row = stg_rom_addr_row[k*ROWO_AW +: ROWO_AW];
               rom_en_row   = stg_rom_en_row[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: a small stage-engine responder answers
// each stg_start after a programmable latency, and runs are timed against hand-derived cycle counts.
module tb_nn_layer_sequencer;

   localparam int NS      = 8;
   localparam int RAM_AW  = 16;
   localparam int RAM_DW  = 8;
   localparam int ROMW_AW = 16;
   localparam int ROWO_AW = 9;
   localparam int TO_W    = 4;

   logic                     sys_clk;
   logic                     rst;
   logic                     startFlag;
   logic                     abortIn;
   logic [NS-1:0]            stageMask;
   logic                     endFlag, busyOut, errTimeout, errSpurious;
   logic [3:0]               curStage;
   logic [31:0]              runCycles;
   logic [NS-1:0]            stgStart, stgEnd, respEnd, injEnd;
   logic [NS*RAM_AW-1:0]     stgRamAddrW, stgRamAddrR;
   logic [NS*RAM_DW-1:0]     stgRamDataW;
   logic [NS-1:0]            stgRamEn, stgRamWea, stgRamEnR, stgRomEnRw, stgRomEnRow;
   logic [NS*ROMW_AW-1:0]    stgRomAddrRw;
   logic [NS*ROWO_AW-1:0]    stgRomAddrRow;
   logic [RAM_AW-1:0]        ramAddrW, ramAddrR;
   logic [RAM_DW-1:0]        ramDataW;
   logic                     ramEn, ramWea, ramEnR, romEnRw, romEnRow;
   logic [ROMW_AW-1:0]       romAddrRw;
   logic [ROWO_AW-1:0]       romAddrRow;

   int                       totalChecks = 0;
   int                       badChecks   = 0;
   int                       cyc = 0;
   int                       runStart, endCount, endCyc, busyCnt, probeGood, probeBad;
   int                       startCyc[NS];
   int                       cnt[NS];
   int                       lat[NS];
   logic [NS-1:0]            startedMask;
   int                       s1, s2;

   assign stgEnd = respEnd | injEnd;

   nn_layer_sequencer #(
      .NUM_STAGES(NS), .RAM_AW(RAM_AW), .RAM_DW(RAM_DW),
      .ROMW_AW(ROMW_AW), .ROWO_AW(ROWO_AW), .TO_W(TO_W)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .start_flag(startFlag), .abort(abortIn),
      .stage_mask(stageMask), .end_flag(endFlag), .busy(busyOut),
      .err_timeout(errTimeout), .err_spurious(errSpurious), .cur_stage(curStage),
      .run_cycles(runCycles), .stg_start(stgStart), .stg_end(stgEnd),
      .stg_ram_addr_w(stgRamAddrW), .stg_ram_data_w(stgRamDataW), .stg_ram_en(stgRamEn),
      .stg_ram_wea(stgRamWea), .stg_ram_addr_r(stgRamAddrR), .stg_ram_en_r(stgRamEnR),
      .stg_rom_addr_rw(stgRomAddrRw), .stg_rom_en_rw(stgRomEnRw),
      .stg_rom_addr_row(stgRomAddrRow), .stg_rom_en_row(stgRomEnRow),
      .ram_addr_w(ramAddrW), .ram_data_w(ramDataW), .ram_en(ramEn), .ram_wea(ramWea),
      .ram_addr_r(ramAddrR), .ram_en_r(ramEnR), .rom_addr_rw(romAddrRw),
      .rom_en_rw(romEnRw), .rom_addr_row(romAddrRow), .rom_en_row(romEnRow)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("[TB] FAIL global-timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock: sample outputs 1ns after the edge, then play the stage engines.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
      if (endFlag) begin
         endCount++;
         endCyc = cyc;
      end
      if (busyOut) busyCnt++;
      startedMask |= stgStart;
      respEnd = '0;
      for (int k = 0; k < NS; k++) begin
         if (cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) respEnd[k] = 1'b1;
         end
         if (stgStart[k]) begin
            startCyc[k] = cyc;
            if (lat[k] > 0) cnt[k] = lat[k];
         end
      end
      if (curStage == 4'd5 && ramAddrW == 16'hA505 && romAddrRw == 16'h5005) probeGood++;
      else if (curStage != 4'd5 && ramAddrW == 16'hA505) probeBad++;
   endtask

   task automatic applyStimulus(input logic [NS-1:0] mask);
      startedMask = '0;
      endCount    = 0;
      busyCnt     = 0;
      probeGood   = 0;
      probeBad    = 0;
      for (int k = 0; k < NS; k++) begin
         cnt[k]      = 0;
         startCyc[k] = -1;
      end
      stageMask = mask;
      startFlag = 1'b1;
      runStart  = cyc;
      tick();
      startFlag = 1'b0;
   endtask

   task automatic waitEnd(input string tag, input int budget);
      int n = 0;
      while (endCount == 0 && n < budget) begin
         tick();
         n++;
      end
      if (endCount == 0) checkOutput({tag, " end_flag-wait"}, 0, 1);
   endtask

   task automatic waitStage(input string tag, input int k, input int budget);
      int n = 0;
      while (!startedMask[k] && n < budget) begin
         tick();
         n++;
      end
      if (!startedMask[k]) checkOutput({tag, " stg_start-wait"}, 0, 1);
   endtask

   initial begin
      rst       = 1'b1;
      startFlag = 1'b0;
      abortIn   = 1'b0;
      stageMask = '0;
      respEnd   = '0;
      injEnd    = '0;
      stgRamEn  = '1;
      stgRamWea = '1;
      stgRamEnR = '1;
      stgRomEnRw  = '1;
      stgRomEnRow = '1;
      for (int k = 0; k < NS; k++) begin
         stgRamAddrW[k*RAM_AW +: RAM_AW]     = 16'hA000 + 16'(k * 257);
         stgRamAddrR[k*RAM_AW +: RAM_AW]     = 16'h3000 + 16'(k);
         stgRamDataW[k*RAM_DW +: RAM_DW]     = 8'(k + 1);
         stgRomAddrRw[k*ROMW_AW +: ROMW_AW]  = 16'h5000 + 16'(k);
         stgRomAddrRow[k*ROWO_AW +: ROWO_AW] = 9'(k + 1);
         lat[k] = 10;
         cnt[k] = 0;
      end
      repeat (3) tick();
      checkOutput("reset end_flag", 32'(endFlag), 0);
      checkOutput("reset busy", 32'(busyOut), 0);
      checkOutput("reset err_timeout", 32'(errTimeout), 0);
      checkOutput("reset err_spurious", 32'(errSpurious), 0);
      checkOutput("reset cur_stage", 32'(curStage), 0);
      checkOutput("reset run_cycles", runCycles, 0);
      checkOutput("reset stg_start", 32'(stgStart), 0);
      checkOutput("reset ram_en", 32'(ramEn), 0);
      checkOutput("reset ram_addr_w", 32'(ramAddrW), 0);
      rst = 1'b0;
      repeat (2) tick();

      // Full chain, 10-cycle stages.
      applyStimulus(8'hFF);
      waitEnd("full", 200);
      checkOutput("full end latency", 32'(endCyc - runStart), 98);
      checkOutput("full first start", 32'(startCyc[0] - runStart), 2);
      for (int k = 1; k < NS; k++)
         checkOutput($sformatf("full start gap %0d", k), 32'(startCyc[k] - startCyc[k-1]), 12);
      checkOutput("full started mask", 32'(startedMask), 32'hFF);
      tick();
      checkOutput("full run_cycles", runCycles, 98);
      checkOutput("full busy cycles", 32'(busyCnt), 98);
      checkOutput("full end count", 32'(endCount), 1);
      checkOutput("full err_timeout", 32'(errTimeout), 0);
      checkOutput("full err_spurious", 32'(errSpurious), 0);
      checkOutput("full idle ram_en", 32'(ramEn), 0);

      // Sparse mask 1010_0100 with bus probe on stage 5.
      applyStimulus(8'hA4);
      waitEnd("sparse", 200);
      checkOutput("sparse started mask", 32'(startedMask), 32'hA4);
      checkOutput("sparse stage2 start", 32'(startCyc[2] - runStart), 2);
      checkOutput("sparse stage7 start", 32'(startCyc[7] - runStart), 26);
      checkOutput("sparse end latency", 32'(endCyc - runStart), 38);
      checkOutput("sparse probe good cycles", 32'(probeGood), 12);
      checkOutput("sparse probe leak cycles", 32'(probeBad), 0);
      tick();
      checkOutput("sparse run_cycles", runCycles, 38);

      // Empty mask.
      applyStimulus(8'h00);
      waitEnd("empty", 20);
      checkOutput("empty end latency", 32'(endCyc - runStart), 2);
      tick();
      checkOutput("empty busy cycles", 32'(busyCnt), 2);
      checkOutput("empty started mask", 32'(startedMask), 0);
      checkOutput("empty run_cycles", runCycles, 2);

      // Watchdog: stage 0 never answers.
      lat[0] = 0;
      applyStimulus(8'h03);
      waitEnd("timeout", 80);
      checkOutput("timeout end after start0", 32'(endCyc - startCyc[0]), 17);
      tick();
      checkOutput("timeout err_timeout", 32'(errTimeout), 1);
      checkOutput("timeout started mask", 32'(startedMask), 32'h01);
      checkOutput("timeout run_cycles", runCycles, 19);
      lat[0] = 10;

      // Abort 3 cycles into stage 2, with a second start while busy.
      applyStimulus(8'hFF);
      checkOutput("abort err_timeout cleared", 32'(errTimeout), 0);
      waitStage("abort", 2, 100);
      s2 = startCyc[2];
      repeat (3) tick();
      abortIn   = 1'b1;
      startFlag = 1'b1;
      tick();
      abortIn   = 1'b0;
      startFlag = 1'b0;
      for (int k = 0; k < NS; k++) cnt[k] = 0;
      waitEnd("abort", 20);
      checkOutput("abort end latency", 32'(endCyc - s2), 5);
      repeat (6) tick();
      checkOutput("abort started mask", 32'(startedMask), 32'h07);
      checkOutput("abort end count", 32'(endCount), 1);
      checkOutput("abort busy after", 32'(busyOut), 0);
      checkOutput("abort err_timeout", 32'(errTimeout), 0);

      // Spurious end from stage 4 while stage 1 runs.
      applyStimulus(8'hFF);
      waitStage("spurious", 1, 100);
      s1 = startCyc[1];
      injEnd = 8'h10;
      tick();
      injEnd = '0;
      checkOutput("spurious flag set", 32'(errSpurious), 1);
      checkOutput("spurious cur_stage", 32'(curStage), 1);
      waitEnd("spurious", 200);
      checkOutput("spurious end latency", 32'(endCyc - runStart), 98);
      checkOutput("spurious started mask", 32'(startedMask), 32'hFF);
      checkOutput("spurious stage2 start", 32'(startCyc[2] - s1), 12);
      tick();
      checkOutput("spurious flag held", 32'(errSpurious), 1);

      // Reset in the middle of a run.
      applyStimulus(8'hFF);
      checkOutput("midreset err_spurious cleared", 32'(errSpurious), 0);
      waitStage("midreset", 3, 100);
      rst = 1'b1;
      for (int k = 0; k < NS; k++) cnt[k] = 0;
      endCount = 0;
      tick();
      checkOutput("midreset busy", 32'(busyOut), 0);
      checkOutput("midreset stg_start", 32'(stgStart), 0);
      checkOutput("midreset cur_stage", 32'(curStage), 0);
      checkOutput("midreset run_cycles", runCycles, 0);
      checkOutput("midreset ram_en", 32'(ramEn), 0);
      checkOutput("midreset ram_addr_w", 32'(ramAddrW), 0);
      rst = 1'b0;
      repeat (30) tick();
      checkOutput("midreset no end_flag", 32'(endCount), 0);
      checkOutput("midreset still idle", 32'(busyOut), 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
